id_stage: RTL

//  Decode stage directly downstream of instruction fetch. Accepts {pc, instruction} beats through a valid/ready handshake.

---
 rtl/rv32_pkg.sv | 65 ++++++
 rtl/rv32_decoder.sv | 115 +++++++++++
 rtl/id_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode types: opcodes, op classes, ALU ops and the decoded bundle.
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL,
    CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_FENCE, CLS_SYSTEM
  } op_class_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_EMPTY, ST_ONE, ST_TWO
  } stage_state_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    op_class_t   op_class;
    alu_op_t     alu_op;
    logic [2:0]  funct3;
    logic        illegal;
  } id_bundle_t;

  // Decoded form of NOP_INSTR (addi x0,x0,0).
  localparam id_bundle_t NOP_BUNDLE = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0,
    op_class: CLS_ALU_I, alu_op: ALU_ADD, funct3: 3'd0, illegal: 1'b0
  };

  // alt selects SUB for funct3=0 and SRA for funct3=5.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_decoder.sv
// Purely combinational RV32I decoder: instruction word to decoded bundle.
module rv32_decoder
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output id_bundle_t  bundle
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    bundle.rs1      = instr[19:15];
    bundle.rs2      = 5'd0;
    bundle.rd       = instr[11:7];
    bundle.imm      = imm_i;
    bundle.op_class = CLS_ALU_I;
    bundle.alu_op   = ALU_ADD;
    bundle.funct3   = funct3;
    bundle.illegal  = 1'b0;

    case (opcode)
      OPC_OP: begin
        bundle.op_class = CLS_ALU_R;
        bundle.rs2      = instr[24:20];
        bundle.imm      = 32'd0;
        bundle.alu_op   = alu_from_funct3(funct3, funct7[5]);
        bundle.illegal  = !((funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      end
      OPC_OP_IMM: begin
        // Only the shift-right immediate carries an ALU selector in funct7.
        bundle.alu_op  = alu_from_funct3(funct3, (funct3 == 3'd5) && funct7[5]);
        bundle.illegal = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
                         ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      OPC_LOAD: begin
        bundle.op_class = CLS_LOAD;
        bundle.illegal  = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        bundle.op_class = CLS_STORE;
        bundle.rs2      = instr[24:20];
        bundle.rd       = 5'd0;
        bundle.imm      = imm_s;
        bundle.illegal  = (funct3 > 3'd2);
      end
      OPC_BRANCH: begin
        bundle.op_class = CLS_BRANCH;
        bundle.rs2      = instr[24:20];
        bundle.rd       = 5'd0;
        bundle.imm      = imm_b;
        bundle.alu_op   = ALU_SUB;
        bundle.illegal  = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_JAL: begin
        bundle.op_class = CLS_JAL;
        bundle.rs1      = 5'd0;
        bundle.imm      = imm_j;
      end
      OPC_JALR: begin
        bundle.op_class = CLS_JALR;
        bundle.illegal  = (funct3 != 3'd0);
      end
      OPC_LUI: begin
        bundle.op_class = CLS_LUI;
        bundle.rs1      = 5'd0;
        bundle.imm      = imm_u;
        bundle.alu_op   = ALU_PASSB;
      end
      OPC_AUIPC: begin
        bundle.op_class = CLS_AUIPC;
        bundle.rs1      = 5'd0;
        bundle.imm      = imm_u;
      end
      OPC_MISC_MEM: begin
        bundle.op_class = CLS_FENCE;
        bundle.rd       = 5'd0;
      end
      OPC_SYSTEM: begin
        bundle.op_class = CLS_SYSTEM;
      end
      default: begin
        bundle.illegal = 1'b1;
      end
    endcase

    if (instr[1:0] != 2'b11) begin
      bundle.illegal = 1'b1;
    end

    // Illegal words travel as a NOP so execute never acts on garbage fields.
    if (bundle.illegal) begin
      bundle         = NOP_BUNDLE;
      bundle.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: combinational RV32I decode into a 2-entry registered skid buffer.
module id_stage
  import rv32_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ILLEGAL_PASS = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            if_ready,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [31:0]     id_imm,
  output logic [3:0]      id_op_class,
  output logic [3:0]      id_alu_op,
  output logic [2:0]      id_funct3,
  output logic            id_illegal
);

  localparam logic PASS_ILLEGAL = (ILLEGAL_PASS != 0);

  stage_state_t    state_q;
  stage_state_t    state_d;
  logic            if_ready_q;
  logic            in_xfer;
  logic            in_load;
  logic            out_xfer;
  logic            load_o_new;
  logic            load_o_skid;
  logic            load_s;

  id_bundle_t      dec_p0;
  id_bundle_t      out_p1;
  id_bundle_t      skid_p1;
  logic [XLEN-1:0] out_pc_p1;
  logic [XLEN-1:0] skid_pc_p1;

  // Stage p0: decode the incoming fetch beat.
  rv32_decoder u_decoder (
    .instr  (if_instr),
    .bundle (dec_p0)
  );

  assign in_xfer  = if_valid & if_ready_q;
  // A dropped illegal beat is still handshaken, it just never occupies a slot.
  assign in_load  = in_xfer & (PASS_ILLEGAL | ~dec_p0.illegal);
  assign id_valid = (state_q != ST_EMPTY);
  assign out_xfer = id_valid & ex_ready;

  always_comb begin
    state_d     = state_q;
    load_o_new  = 1'b0;
    load_o_skid = 1'b0;
    load_s      = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (in_load) begin
          state_d    = ST_ONE;
          load_o_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_load && out_xfer) begin
          load_o_new = 1'b1;
        end else if (in_load) begin
          state_d = ST_TWO;
          load_s  = 1'b1;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          state_d     = ST_ONE;
          load_o_skid = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (flush) begin
      state_d     = ST_EMPTY;
      load_o_new  = 1'b0;
      load_o_skid = 1'b0;
      load_s      = 1'b0;
    end
  end

  // Stage p1: output register O and skid register S.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      if_ready_q <= 1'b1;
      out_p1     <= NOP_BUNDLE;
      out_pc_p1  <= '0;
    end else begin
      state_q    <= state_d;
      if_ready_q <= (state_d != ST_TWO);
      if (load_o_new) begin
        out_p1    <= dec_p0;
        out_pc_p1 <= if_pc;
      end else if (load_o_skid) begin
        out_p1    <= skid_p1;
        out_pc_p1 <= skid_pc_p1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (load_s) begin
      skid_p1    <= dec_p0;
      skid_pc_p1 <= if_pc;
    end
  end

  assign if_ready    = if_ready_q;
  assign id_pc       = out_pc_p1;
  assign id_rs1      = out_p1.rs1;
  assign id_rs2      = out_p1.rs2;
  assign id_rd       = out_p1.rd;
  assign id_imm      = out_p1.imm;
  assign id_op_class = out_p1.op_class;
  assign id_alu_op   = out_p1.alu_op;
  assign id_funct3   = out_p1.funct3;
  assign id_illegal  = out_p1.illegal;

endmodule
